// File: rtl/as5600_i2c_responder.sv
// as5600_i2c_responder: I2C target emulating the AS5600 angle/status read path.
// SCL/SDA are oversampled on clock; START/STOP override every state.
module as5600_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [11:0] raw_angle,
  input  logic        magnet_detected,
  output logic        busy,
  output logic        rd_done
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_STAGES:0] scl_q, sda_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d, pointer_q, pointer_d, byte_c;
  logic [11:0]       snap_q, snap_d;
  logic              rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d, rd_any_q, rd_any_d;
  logic              scl_c, sda_c, scl_rise, scl_fall, start_c, stop_c;

  assign scl_c    = scl_q[SYNC_STAGES-1];
  assign sda_c    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_c & ~scl_q[SYNC_STAGES];
  assign scl_fall = ~scl_c & scl_q[SYNC_STAGES];
  assign start_c  = scl_c & scl_q[SYNC_STAGES] & sda_q[SYNC_STAGES] & ~sda_c;
  assign stop_c   = scl_c & scl_q[SYNC_STAGES] & ~sda_q[SYNC_STAGES] & sda_c;
  assign byte_c   = (pointer_q == 8'h0B) ? {2'b0, magnet_detected, 5'b0} :
                    (pointer_q == 8'h0C || pointer_q == 8'h0E) ? {4'h0, snap_q[11:8]} :
                    (pointer_q == 8'h0D || pointer_q == 8'h0F) ? snap_q[7:0] : 8'h00;
  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign rd_done  = done_q;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scl_q     <= '1;
      sda_q     <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      pointer_q <= '0;
      snap_q    <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_any_q  <= 1'b0;
    end else begin
      scl_q     <= {scl_q[SYNC_STAGES-1:0], scl};
      sda_q     <= {sda_q[SYNC_STAGES-1:0], sda_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      pointer_q <= pointer_d;
      snap_q    <= snap_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_any_q  <= rd_any_d;
    end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    pointer_d = pointer_q;
    snap_d    = snap_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_any_d  = rd_any_q;
    if (start_c || stop_c) begin
      state_d  = start_c ? ADDR : IDLE;
      cnt_d    = '0;
      oe_d     = 1'b0;
      busy_d   = start_c & busy_q;
      done_d   = rd_any_q;
      rd_any_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA:
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_c};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              state_d = (shift_q[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
              oe_d    = shift_q[7:1] == DEV_ADDR;
              busy_d  = busy_q | (shift_q[7:1] == DEV_ADDR);
              rw_d    = shift_q[0];
              snap_d  = (shift_q[7:1] == DEV_ADDR && shift_q[0]) ? raw_angle : snap_q;
            end else begin
              state_d   = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
              oe_d      = 1'b1;
              pointer_d = (state_q == PTR) ? shift_q : pointer_q + 8'd1;
            end
          end
        ADDR_ACK, PTR_ACK, WDATA_ACK, RD_ACK:
          if (state_q == RD_ACK && scl_rise && sda_c) state_d = IGNORE;
          else if (scl_fall) begin
            // a read-direction ACK hands straight over to driving the first data bit
            state_d = (state_q == RD_ACK || (state_q == ADDR_ACK && rw_q)) ? RDATA :
                      (state_q == ADDR_ACK) ? PTR : WDATA;
            shift_d = byte_c;
            oe_d    = (state_d == RDATA) & ~byte_c[7];
            cnt_d   = (state_d == RDATA) ? 4'd1 : 4'd0;
          end
        RDATA:
          if (scl_fall) begin
            state_d   = (cnt_q == 4'd8) ? RD_ACK : RDATA;
            oe_d      = (cnt_q != 4'd8) & ~shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            cnt_d     = cnt_q + 4'd1;
            pointer_d = (cnt_q == 4'd8) ? pointer_q + 8'd1 : pointer_q;
            rd_any_d  = rd_any_q | (cnt_q == 4'd8);
          end
        IGNORE:  oe_d = 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_as5600_i2c_responder.sv
// tb_as5600_i2c_responder: bit-banged I2C master against a register-map model of the AS5600 read path.
module tb_as5600_i2c_responder;
  localparam int Q = 10;
  localparam int SYNC = 2;
  logic        clock = 1'b0, reset_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, override = 1'b0;
  logic [11:0] raw_angle = '0;
  logic        magnet_detected = 1'b0;
  logic        sda_oe, busy, rd_done, sda_i;
  int          errors = 0, checks = 0, rd_pulses = 0, oe_cycles = 0, busy_cycles = 0;
  logic        ack_r;
  logic [7:0]  rx [8];

  // open-drain pad; override lets the master create a STOP the wired-AND would mask
  assign sda_i = override ? sda_m : (sda_m & ~sda_oe);

  as5600_i2c_responder #(.DEV_ADDR(7'h36), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset_n(reset_n), .scl(scl_m), .sda_i(sda_i), .sda_oe(sda_oe),
    .raw_angle(raw_angle), .magnet_detected(magnet_detected), .busy(busy), .rd_done(rd_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_done) rd_pulses <= rd_pulses + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  function automatic logic [7:0] model_reg(input logic [7:0] a, input logic [11:0] s, input logic md);
    if (a == 8'h0B) return md ? 8'h20 : 8'h00;
    if (a == 8'h0C || a == 8'h0E) return {4'h0, s[11:8]};
    if (a == 8'h0D || a == 8'h0F) return s[7:0];
    return 8'h00;
  endfunction

  task automatic half();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; half(); scl_m = 1'b1; half(); sda_m = 1'b0; half(); scl_m = 1'b0; half();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half(); scl_m = 1'b1; half(); sda_m = 1'b1; half();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; half(); scl_m = 1'b1; half(); scl_m = 1'b0; half();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; half(); scl_m = 1'b1;
    repeat (Q / 2) @(negedge clock);
    b = sda_i;
    repeat (Q / 2) @(negedge clock);
    scl_m = 1'b0; half();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start(); write_byte(8'h6C, a); write_byte(p, a); i2c_stop();
  endtask

  task automatic do_read(input int n);
    i2c_start(); write_byte(8'h6D, ack_r);
    for (int i = 0; i < n; i++) read_byte(rx[i], i == n - 1);
    i2c_stop();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done got=%b exp=0", rd_done); end
    reset_n = 1'b1; half();
  endtask

  task automatic test_ptr_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int p0;
    raw_angle = 12'hABC;
    i2c_start(); write_byte(8'h6C, a0); write_byte(8'h0C, a1);
    p0 = rd_pulses;
    i2c_start(); write_byte(8'h6D, a2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ptr_read_busy got=%b exp=1", busy); end
    read_byte(d0, 1'b0); read_byte(d1, 1'b1);
    checks++; if (rd_pulses != p0) begin errors++; $display("FAIL ptr_read_no_done_at_nack got=%0d exp=0", rd_pulses - p0); end
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL ptr_read_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h0A) begin errors++; $display("FAIL ptr_read_hi got=%h exp=0a", d0); end
    checks++; if (d1 !== 8'hBC) begin errors++; $display("FAIL ptr_read_lo got=%h exp=bc", d1); end
    checks++; if (rd_pulses - p0 != 1) begin errors++; $display("FAIL ptr_read_rd_done got=%0d exp=1", rd_pulses - p0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ptr_read_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int o0, b0;
    o0 = oe_cycles; b0 = busy_cycles;
    i2c_start(); write_byte(8'h6E, a0); write_byte(8'h55, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wrong_addr_nack got=%b exp=11", {a0, a1}); end
    checks++; if (oe_cycles != o0) begin errors++; $display("FAIL wrong_addr_sda_oe got=%0d exp=0 cycles", oe_cycles - o0); end
    checks++; if (busy_cycles != b0) begin errors++; $display("FAIL wrong_addr_busy got=%0d exp=0 cycles", busy_cycles - b0); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d0, d1;
    logic a;
    set_ptr(8'h0C);
    raw_angle = 12'h123;
    i2c_start(); write_byte(8'h6D, a);
    read_byte(d0, 1'b0);
    raw_angle = 12'hFFF;
    read_byte(d1, 1'b1); i2c_stop();
    checks++; if ({d0, d1} !== 16'h0123) begin errors++; $display("FAIL snapshot got=%h exp=0123", {d0, d1}); end
  endtask

  task automatic test_wrap();
    raw_angle = 12'h5A5;
    set_ptr(8'hFF); do_read(2);
    checks++; if ({rx[0], rx[1]} !== 16'h0000) begin errors++; $display("FAIL wrap got=%h exp=0000", {rx[0], rx[1]}); end
    magnet_detected = 1'b1; set_ptr(8'h0B); do_read(1);
    checks++; if (rx[0] !== 8'h20) begin errors++; $display("FAIL status_md1 got=%h exp=20", rx[0]); end
    magnet_detected = 1'b0; set_ptr(8'h0B); do_read(1);
    checks++; if (rx[0] !== 8'h00) begin errors++; $display("FAIL status_md0 got=%h exp=00", rx[0]); end
  endtask

  task automatic test_write_data();
    logic a0, a1, a2, a3;
    raw_angle = 12'h3C7;
    i2c_start(); write_byte(8'h6C, a0); write_byte(8'h0A, a1); write_byte(8'h5A, a2); write_byte(8'hA5, a3);
    do_read(2);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wdata_acks got=%b exp=0000", {a0, a1, a2, a3}); end
    checks++; if ({rx[0], rx[1]} !== 16'h03C7) begin errors++; $display("FAIL wdata_ptr_incr got=%h exp=03c7", {rx[0], rx[1]}); end
  endtask

  task automatic test_stop_mid_read();
    logic a;
    int n;
    raw_angle = 12'hABC;
    set_ptr(8'h0C);
    i2c_start(); write_byte(8'h6D, a);
    repeat (5) @(negedge clock);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL stop_mid_driving got=%b exp=1", sda_oe); end
    override = 1'b1; sda_m = 1'b0; half(); scl_m = 1'b1; half();
    sda_m = 1'b1;
    n = 0;
    while (sda_oe === 1'b1 && n <= SYNC + 1) begin @(posedge clock); #1; n++; end
    checks++; if (n > SYNC + 1) begin errors++; $display("FAIL stop_mid_release got=%0d cycles exp<=%0d", n, SYNC + 1); end
    half(); override = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_mid_busy got=%b exp=0", busy); end
    do_read(1);
    checks++; if (rx[0] !== 8'h0A) begin errors++; $display("FAIL stop_mid_resume got=%h exp=0a", rx[0]); end
  endtask

  task automatic test_reset_in_ack();
    int n;
    raw_angle = 12'hABC;
    set_ptr(8'h0C);
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b1 : (8'h6D >> i) & 8'h01);
    n = 0;
    while (sda_oe !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_ack_driving got=%b exp=1", sda_oe); end
    reset_n = 1'b0; #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_ack_release got=%b exp=0", sda_oe); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1; scl_m = 1'b1; sda_m = 1'b1; half();
    do_read(1);
    checks++; if (rx[0] !== 8'h00) begin errors++; $display("FAIL rst_ack_pointer got=%h exp=00", rx[0]); end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [11:0] s;
    logic a0, a1;
    int n, p0;
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(0, 1) ? 8'h0A + 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      s = 12'($urandom); raw_angle = s;
      magnet_detected = 1'($urandom);
      n = $urandom_range(1, 4);
      p0 = rd_pulses;
      i2c_start(); write_byte(8'h6C, a0); write_byte(p, a1);
      do_read(n);
      checks++; if ({a0, a1, ack_r} !== 3'b000) begin errors++; $display("FAIL rand_acks it=%0d got=%b exp=000", it, {a0, a1, ack_r}); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx[i] !== model_reg(p + 8'(i), s, magnet_detected)) begin
          errors++; $display("FAIL rand_byte it=%0d reg=%h got=%h exp=%h", it, p + 8'(i), rx[i], model_reg(p + 8'(i), s, magnet_detected));
        end
      end
      checks++; if (rd_pulses - p0 != 1) begin errors++; $display("FAIL rand_rd_done it=%0d got=%0d exp=1", it, rd_pulses - p0); end
    end
  endtask

  initial begin
    test_reset();
    test_ptr_read();
    test_wrong_addr();
    test_snapshot();
    test_wrap();
    test_write_data();
    test_stop_mid_read();
    test_reset_in_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
